// File: rtl/lfsr_pkg.sv
// lfsr_pkg: sizes, seed and LFSR step shared by the checker and the writer-side LFSR.
package lfsr_pkg;
  localparam int DW = 4;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam logic [DW-1:0] SEED = 4'b1001;
  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;
  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] e);
    return {e[DW-2:0], e[DW-1] ^ e[DW-3]};
  endfunction
endpackage

// File: rtl/lfsr_ref.sv
// lfsr_ref: seed-loaded reference LFSR; can step twice when a sample is captured and one is dropped together.
module lfsr_ref import lfsr_pkg::*; #(
  parameter logic [DW-1:0] INIT = SEED
) (
  input  logic          clk_125MHz,
  input  logic          reset_n,
  input  logic          i_adv,
  input  logic          i_drop,
  output logic [DW-1:0] o_value
);
  logic [DW-1:0] r_value;
  logic [DW-1:0] w_step;
  assign w_step = i_adv ? lfsr_next(r_value) : r_value;
  assign o_value = r_value;
  always_ff @(posedge clk_125MHz or negedge reset_n)
    if (!reset_n) r_value <= INIT;
    else r_value <= i_drop ? lfsr_next(w_step) : w_step;
endmodule

// File: rtl/lfsr_bram_checker.sv
// lfsr_bram_checker: drains a circular sample buffer and checks each sample against a reference LFSR.
module lfsr_bram_checker #(
  parameter int DW = lfsr_pkg::DW,
  parameter int AW = lfsr_pkg::AW,
  parameter int DEPTH = lfsr_pkg::DEPTH,
  parameter logic [DW-1:0] SEED = lfsr_pkg::SEED
) (
  input  logic          clk_125MHz,
  input  logic          reset_n,
  input  logic          wr_pulse,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mismatch,
  output logic [7:0]    err_count,
  output logic          overrun,
  input  logic          clear
);
  import lfsr_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  state_t r_state, w_next;
  logic [AW-1:0] r_rd_ptr, w_ptr_inc;
  logic [CW-1:0] r_count;
  logic [DW-1:0] w_expected;
  logic w_read, w_capture, w_drop, w_mismatch;
  assign w_read = r_state == READ;
  assign w_capture = r_state == WAIT;
  // a write into a full buffer with no read to make room discards the oldest entry
  assign w_drop = wr_pulse && !w_read && r_count == CW'(DEPTH);
  assign w_mismatch = w_capture && rd_data != w_expected;
  assign w_ptr_inc = r_rd_ptr == AW'(DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
  assign rd_en = w_read;
  assign rd_addr = r_rd_ptr;
  assign out_valid = r_state == HOLD;
  lfsr_ref #(.INIT(SEED)) u_ref (
    .clk_125MHz(clk_125MHz),
    .reset_n(reset_n),
    .i_adv(w_capture),
    .i_drop(w_drop),
    .o_value(w_expected)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = r_count != '0 ? READ : IDLE;
      READ: w_next = WAIT;
      WAIT: w_next = HOLD;
      HOLD: w_next = out_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_125MHz or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_rd_ptr <= '0;
      r_count <= CW'(1);
      out_data <= '0;
      out_mismatch <= 1'b0;
      err_count <= '0;
      overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_read || w_drop) r_rd_ptr <= w_ptr_inc;
      if (wr_pulse && !w_read && !w_drop) r_count <= r_count + 1'b1;
      else if (w_read && !wr_pulse) r_count <= r_count - 1'b1;
      if (w_capture) begin
        out_data <= rd_data;
        out_mismatch <= w_mismatch;
      end
      if (w_mismatch) err_count <= err_count + {7'd0, err_count != 8'hFF};
      else if (clear) err_count <= '0;
      if (w_drop) overrun <= 1'b1;
      else if (clear) overrun <= 1'b0;
    end
endmodule

// File: tb/tb_lfsr_bram_checker.sv
// tb_lfsr_bram_checker: directed scenarios against a behavioural buffer with hand-computed expectations.
module tb_lfsr_bram_checker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_pulse = 1'b0;
  logic rd_en;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_mismatch;
  logic [7:0] err_count;
  logic overrun;
  logic clear = 1'b0;
  logic [3:0] mem [8];
  logic [2:0] wr_ptr;
  int passed = 0;
  int total = 0;

  lfsr_bram_checker dut (
    .clk_125MHz(clk),
    .reset_n(reset_n),
    .wr_pulse(wr_pulse),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mismatch(out_mismatch),
    .err_count(err_count),
    .overrun(overrun),
    .clear(clear)
  );

  always #4 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic init_mem();
    for (int i = 0; i < 8; i++) mem[i] = 4'b0000;
    mem[0] = 4'b1001;
    wr_ptr = 3'd1;
  endtask

  task automatic do_reset(input logic rdy);
    reset_n = 1'b0;
    clear = 1'b0;
    wr_pulse = 1'b0;
    out_ready = rdy;
    init_mem();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 3'd1;
    wr_pulse = 1'b1;
    @(negedge clk);
    wr_pulse = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    init_mem();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", rd_en); else passed++;
    total++; if (rd_addr !== 3'd0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 4'b0000) $display("FAIL reset_out_data got %b want 0000", out_data); else passed++;
    total++; if (out_mismatch !== 1'b0) $display("FAIL reset_mismatch got %b want 0", out_mismatch); else passed++;
    total++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
    total++; if (dut.r_count !== 4'd1) $display("FAIL reset_count got %0d want 1", dut.r_count); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (rd_en !== 1'b1 || rd_addr !== 3'd0) $display("FAIL first_read got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL early_valid got %b want 0", out_valid); else passed++;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL latency_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 4'b1001 || out_mismatch !== 1'b0) $display("FAIL seed_sample got %b mm=%b want 1001 mm=0", out_data, out_mismatch); else passed++;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0 || rd_en !== 1'b0 || dut.r_count !== 4'd0) $display("FAIL idle_after got valid=%b en=%b count=%0d want 0 0 0", out_valid, rd_en, dut.r_count); else passed++;
  endtask

  task automatic test_stream();
    logic [3:0] vals [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_entry(vals[i]);
    total++; if (dut.r_count !== 4'd4) $display("FAIL stream_count got %0d want 4", dut.r_count); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      if (!ok) begin total++; $display("FAIL stream_timeout sample %0d got no out_valid want out_valid", i); end
      total++; if (out_data !== vals[i] || out_mismatch !== 1'b0) $display("FAIL stream_sample%0d got %b mm=%b want %b mm=0", i, out_data, out_mismatch, vals[i]); else passed++;
      @(negedge clk);
    end
    total++; if (err_count !== 8'd0) $display("FAIL stream_err got %0d want 0", err_count); else passed++;
    total++; if (rd_addr !== 3'd6) $display("FAIL stream_rd_ptr got %0d want 6", rd_addr); else passed++;
  endtask

  task automatic test_mismatch();
    logic [3:0] vals [4] = '{4'b1001, 4'b0011, 4'b0000, 4'b1111};
    logic mm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] errs [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
    bit ok;
    do_reset(1'b0);
    write_entry(4'b0011);
    write_entry(4'b0000);
    write_entry(4'b1111);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      if (!ok) begin total++; $display("FAIL mm_timeout sample %0d got no out_valid want out_valid", i); end
      total++; if (out_data !== vals[i] || out_mismatch !== mm[i] || err_count !== errs[i])
        $display("FAIL mm_sample%0d got %b mm=%b err=%0d want %b mm=%b err=%0d", i, out_data, out_mismatch, err_count, vals[i], mm[i], errs[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] vals [9] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1001, 4'b0011, 4'b0111, 4'b1111};
    bit ok;
    do_reset(1'b0);
    wait_valid(ok);
    if (!ok) begin total++; $display("FAIL ovr_timeout got no out_valid want out_valid"); end
    for (int i = 0; i < 8; i++) write_entry(vals[i]);
    total++; if (dut.r_count !== 4'd8 || overrun !== 1'b0) $display("FAIL ovr_full got count=%0d ovr=%b want 8 0", dut.r_count, overrun); else passed++;
    write_entry(vals[8]);
    total++; if (overrun !== 1'b1 || dut.r_count !== 4'd8) $display("FAIL ovr_set got ovr=%b count=%0d want 1 8", overrun, dut.r_count); else passed++;
    total++; if (out_valid !== 1'b1 || out_data !== 4'b1001) $display("FAIL ovr_hold got valid=%b data=%b want 1 1001", out_valid, out_data); else passed++;
    total++; if (rd_addr !== 3'd2) $display("FAIL ovr_drop_ptr got %0d want 2", rd_addr); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    wait_valid(ok);
    if (!ok) begin total++; $display("FAIL ovr_next_timeout got no out_valid want out_valid"); end
    total++; if (out_data !== 4'b0111 || out_mismatch !== 1'b0) $display("FAIL ovr_next got %b mm=%b want 0111 mm=0", out_data, out_mismatch); else passed++;
  endtask

  task automatic test_saturate_clear();
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      write_entry(4'b0000);
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    total++; if (err_count !== 8'd255 || overrun !== 1'b0) $display("FAIL sat_err got err=%0d ovr=%b want 255 0", err_count, overrun); else passed++;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) write_entry(4'b0000);
    total++; if (overrun !== 1'b1 || err_count !== 8'd255) $display("FAIL sat_ovr got ovr=%b err=%0d want 1 255", overrun, err_count); else passed++;
    clear = 1'b1;
    write_entry(4'b0000);
    clear = 1'b0;
    total++; if (overrun !== 1'b1 || err_count !== 8'd0) $display("FAIL clear_prio got ovr=%b err=%0d want 1 0", overrun, err_count); else passed++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (overrun !== 1'b0 || err_count !== 8'd0) $display("FAIL clear got ovr=%b err=%0d want 0 0", overrun, err_count); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(1'b0);
    wait_valid(ok);
    if (!ok) begin total++; $display("FAIL mid_timeout got no out_valid want out_valid"); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 4'b0000) $display("FAIL mid_reset got valid=%b data=%b want 0 0000", out_valid, out_data); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (rd_en !== 1'b1 || rd_addr !== 3'd0) $display("FAIL mid_reread got en=%b addr=%0d want 1 0", rd_en, rd_addr); else passed++;
    wait_valid(ok);
    if (!ok) begin total++; $display("FAIL mid_timeout2 got no out_valid want out_valid"); end
    total++; if (out_data !== 4'b1001) $display("FAIL mid_sample got %b want 1001", out_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_overrun();
    test_saturate_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lfsr_bram_checker.md
LFSR_BRAM_CHECKER -- requirements
Module: lfsr_bram_checker

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DW, 4, sample width.
- AW, 3, buffer address width.
- DEPTH, 8, buffer entries.
- SEED, 4'b1001, first expected sample.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk_125MHz  in  1  sole clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_pulse  in  1  one-cycle writer commit strobe; one entry added.
- rd_en  out  1  buffer read enable.
- rd_addr  out  AW  buffer read address.
- rd_data  in  DW  buffer read data; valid 1 cycle after rd_en.
- out_data  out  DW  sample read from the buffer.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the sample.
- out_mismatch  out  1  out_data differs from the expected LFSR value.
- err_count  out  8  saturating mismatch count.
- overrun  out  1  sticky; writer lapped the reader.
- clear  in  1  synchronous clear of err_count and overrun.

Function
REQ-003 SHALL keep occupancy count, 0..DEPTH, 4 bits wide; +1 on wr_pulse; -1 on a read issue; unchanged when both occur in the same cycle.
REQ-004 SHALL use FSM states IDLE, READ, WAIT, HOLD:
- IDLE->READ when count>0.
- READ->WAIT unconditionally.
- WAIT->HOLD unconditionally.
- HOLD->IDLE when out_ready=1.
REQ-005 In READ, SHALL assert rd_en=1 with rd_addr=rd_ptr, decrement count, and advance rd_ptr modulo DEPTH (7 wraps to 0).
REQ-006 In WAIT, SHALL capture rd_data into out_data and compare it with expected.
REQ-007 SHALL set out_mismatch=(rd_data!=expected); if set, err_count increments, saturating at 255.
REQ-008 SHALL assert out_valid only in HOLD; out_data and out_mismatch stay stable while out_valid=1 and out_ready=0.
REQ-009 Latency: out_valid SHALL rise exactly 2 cycles after the READ cycle.
REQ-010 SHALL advance expected by one LFSR step per captured sample: next={e[2:0], e[3]^e[1]}, period 6 from SEED.
REQ-011 SHALL NOT resync expected to rd_data after a mismatch.
REQ-012 Overrun:
- wr_pulse with count==DEPTH and no read issue that cycle sets overrun=1.
- count stays DEPTH.
- rd_ptr and expected each advance one step (oldest entry dropped).
REQ-013 A read issue plus wr_pulse at count==DEPTH SHALL NOT set overrun.
REQ-014 clear=1 SHALL zero err_count and overrun next cycle; a same-cycle mismatch or overrun event SHALL take priority over clear.
REQ-015 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-016 SHALL, on reset_n=0, immediately set:
- state=IDLE, rd_ptr=0, count=1 (seed entry present at address 0), expected=SEED.
- rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_mismatch=0, err_count=0, overrun=0.
REQ-017 Reset asserted mid-transaction SHALL discard any held sample with no residual output.
REQ-018 Release SHALL be synchronous; first READ occurs in the first cycle after release.

Structure
REQ-019 Shared package lfsr_pkg SHALL hold DW, AW, DEPTH, SEED and the LFSR next-value function, shared with the writer-side LFSR.
REQ-020 SHALL instantiate one sub-module lfsr_ref: a SEED-loaded reference LFSR with advance enable, producing expected.

Verification
REQ-021 SHALL cover these directed scenarios:
- Reset release, no wr_pulse, out_ready=1 -> rd_addr=0 read; out_data=1001, out_mismatch=0; then IDLE with count=0.
- 5 wr_pulse, buffer holding 0011,0111,1111,1110,1100 -> outputs in that order; err_count=0; rd_ptr=6.
- Entry 2 holds 0000 -> sample 0000 flagged out_mismatch=1, err_count=1; next sample 1111 passes.
- out_ready=0 after first sample, 9 wr_pulse -> count=8 after 8th pulse; overrun=1 on 9th; held out_data=1001 unchanged.
- 300 corrupted samples -> err_count=255; clear=1 -> err_count=0, overrun=0.
- reset_n low while out_valid=1 -> out_valid=0 same cycle; after release rd_addr=0, out_data=1001.
